id_rm_pipe: RTL and testbench

ID_RM_PIPE -- requirements
Module: id_rm_pipe

---
 rtl/id_rm_pipe_pkg.sv | 42 ++++
 rtl/id_rm_pipe_scoreboard.sv | 61 ++++++
 rtl/id_rm_pipe.sv | 167 ++++++++++++++++
 tb/tb_id_rm_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_rm_pipe_pkg.sv
// Shared decode constants for the R/M-type issue stage.
// Latency: n/a (constants, types and a pure decode helper only).
// Backpressure: n/a.
// Contents: default widths, opcode/funct7 codes, zero-register index,
//           enable/disable levels, instruction class enum and classifier.
package id_rm_pipe_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_RADDR_WIDTH = 5;
   localparam int DEF_MAX_PEND    = 4;

   localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
   localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCT7_MUL    = 7'b0000001;

   localparam int ZERO_REG = 0;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic READ_ENABLE   = 1'b1;
   localparam logic READ_DISABLE  = 1'b0;

   typedef enum logic [1:0] {
      CLS_OTHER   = 2'd0,
      CLS_ALU     = 2'd1,
      CLS_MUL     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } inst_cls_e;

   function automatic inst_cls_e classify(input logic [6:0] opcode, input logic [6:0] funct7);
      inst_cls_e cls;
      cls = CLS_OTHER;
      if (opcode == INST_TYPE_R_M) begin
         if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) cls = CLS_ALU;
         else if (funct7 == FUNCT7_MUL)                       cls = CLS_MUL;
         else                                                  cls = CLS_ILLEGAL;
      end
      return cls;
   endfunction

endpackage

// File: rtl/id_rm_pipe_scoreboard.sv
// Busy-bit scoreboard and pending counter for outstanding M-unit writebacks.
// Latency: set/clear take effect on the next clock edge (no same-cycle bypass).
// Backpressure: none itself; full_o is consumed by the issue stage as a stall.
// Ports: clk/rst; set_i/set_addr_i (M-type issue); clr_i/clr_addr_i (writeback);
//        busy_o (one bit per register); full_o (pending count at MAX_PEND).
module id_rm_scoreboard
   import id_rm_pipe_pkg::*;
#(
   parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
   parameter int MAX_PEND    = DEF_MAX_PEND
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          set_i,
   input  logic [RADDR_WIDTH-1:0]        set_addr_i,
   input  logic                          clr_i,
   input  logic [RADDR_WIDTH-1:0]        clr_addr_i,
   output logic [(1<<RADDR_WIDTH)-1:0]   busy_o,
   output logic                          full_o
);

   localparam int NREG = 1 << RADDR_WIDTH;

   logic [NREG-1:0]        busy_q, busy_d;
   logic [RADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                   set_eff, clr_eff;

   // x0 is never tracked; a writeback to a register that is not busy is a no-op.
   assign set_eff = set_i && (set_addr_i != RADDR_WIDTH'(ZERO_REG));
   assign clr_eff = clr_i && busy_q[clr_addr_i];

   // Clear first, then set, so a same-address collision leaves the bit set
   // while the counter still sees both events.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (clr_eff) begin
         busy_d[clr_addr_i] = 1'b0;
         cnt_d              = cnt_d - RADDR_WIDTH'(1);
      end
      if (set_eff) begin
         busy_d[set_addr_i] = 1'b1;
         cnt_d              = cnt_d + RADDR_WIDTH'(1);
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o = busy_q;
   assign full_o = (cnt_q == RADDR_WIDTH'(MAX_PEND));

endmodule

// File: rtl/id_rm_pipe.sv
// Decode/register-read stage for R-type and M-type ops with hazard stalling.
// Latency: one cycle from accept to out_valid_o; regfile reads are same-cycle.
// Backpressure: output register holds while out_ready_i is low; inst_ready_o
//               drops on a full output, a scoreboard hazard, flush_i or rst.
// Ports: inst_* handshake in; reg1/reg2 read port out/in; out_* decoded op
//        with out_ready_i; flush_i; m_wb_* M-unit writeback completion.
module id_rm_pipe
   import id_rm_pipe_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
   parameter int MAX_PEND    = DEF_MAX_PEND
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inst_valid_i,
   input  logic [DATA_WIDTH-1:0]  inst_i,
   output logic                   inst_ready_o,
   output logic [RADDR_WIDTH-1:0] reg1_raddr_o,
   output logic [RADDR_WIDTH-1:0] reg2_raddr_o,
   output logic                   reg1_re_o,
   output logic                   reg2_re_o,
   input  logic [DATA_WIDTH-1:0]  reg1_rdata_i,
   input  logic [DATA_WIDTH-1:0]  reg2_rdata_i,
   input  logic                   flush_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_WIDTH-1:0]  op1_o,
   output logic [DATA_WIDTH-1:0]  op2_o,
   output logic                   reg_we_o,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic [2:0]             funct3_o,
   output logic                   alt_o,
   output logic                   is_m_o,
   output logic                   illegal_o,
   input  logic                   m_wb_valid_i,
   input  logic [RADDR_WIDTH-1:0] m_wb_addr_i
);

   localparam logic [RADDR_WIDTH-1:0] ZERO_ADDR = RADDR_WIDTH'(ZERO_REG);

   logic [RADDR_WIDTH-1:0] rd, rs1, rs2;
   logic [2:0]             funct3;
   inst_cls_e              cls;
   logic                   is_rm, hazard, accept, sb_full;
   logic [(1<<RADDR_WIDTH)-1:0] busy;

   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d;
   logic                   reg_we_q, reg_we_d;
   logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
   logic [2:0]             funct3_q, funct3_d;
   logic                   alt_q, alt_d, is_m_q, is_m_d, illegal_q, illegal_d;

   assign rd     = RADDR_WIDTH'(inst_i[11:7]);
   assign rs1    = RADDR_WIDTH'(inst_i[19:15]);
   assign rs2    = RADDR_WIDTH'(inst_i[24:20]);
   assign funct3 = inst_i[14:12];
   assign cls    = classify(inst_i[6:0], inst_i[31:25]);
   assign is_rm  = inst_valid_i && (cls == CLS_ALU || cls == CLS_MUL);

   assign reg1_raddr_o = is_rm ? rs1 : ZERO_ADDR;
   assign reg2_raddr_o = is_rm ? rs2 : ZERO_ADDR;
   assign reg1_re_o    = is_rm ? READ_ENABLE : READ_DISABLE;
   assign reg2_re_o    = is_rm ? READ_ENABLE : READ_DISABLE;

   // Checking rd as well as the sources avoids a WAW race with an in-flight
   // M-unit result landing after this op's own writeback.
   assign hazard = is_rm && ((busy[rs1] && rs1 != ZERO_ADDR) ||
                             (busy[rs2] && rs2 != ZERO_ADDR) ||
                             (busy[rd]  && rd  != ZERO_ADDR) ||
                             (cls == CLS_MUL && sb_full));

   assign inst_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i && !rst;
   assign accept       = inst_valid_i && inst_ready_o;

   id_rm_scoreboard #(
      .RADDR_WIDTH (RADDR_WIDTH),
      .MAX_PEND    (MAX_PEND)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_i      (accept && cls == CLS_MUL),
      .set_addr_i (rd),
      .clr_i      (m_wb_valid_i),
      .clr_addr_i (m_wb_addr_i),
      .busy_o     (busy),
      .full_o     (sb_full)
   );

   // Non-R/M opcodes still produce a valid all-zero bubble so downstream
   // sees one slot per accepted instruction.
   always_comb begin
      out_valid_d = out_valid_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      reg_we_d    = reg_we_q;
      reg_waddr_d = reg_waddr_q;
      funct3_d    = funct3_q;
      alt_d       = alt_q;
      is_m_d      = is_m_q;
      illegal_d   = illegal_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         op1_d       = '0;
         op2_d       = '0;
         reg_we_d    = WRITE_DISABLE;
         reg_waddr_d = ZERO_ADDR;
         funct3_d    = 3'b000;
         alt_d       = 1'b0;
         is_m_d      = 1'b0;
         illegal_d   = 1'b0;
         case (cls)
            CLS_ALU, CLS_MUL: begin
               op1_d       = reg1_rdata_i;
               op2_d       = reg2_rdata_i;
               reg_we_d    = WRITE_ENABLE;
               reg_waddr_d = rd;
               funct3_d    = funct3;
               alt_d       = inst_i[30];
               is_m_d      = (cls == CLS_MUL);
            end
            CLS_ILLEGAL: illegal_d = 1'b1;
            default: ;
         endcase
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         reg_we_q    <= WRITE_DISABLE;
         reg_waddr_q <= '0;
         funct3_q    <= '0;
         alt_q       <= 1'b0;
         is_m_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         reg_we_q    <= reg_we_d;
         reg_waddr_q <= reg_waddr_d;
         funct3_q    <= funct3_d;
         alt_q       <= alt_d;
         is_m_q      <= is_m_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign op1_o       = op1_q;
   assign op2_o       = op2_q;
   assign reg_we_o    = reg_we_q;
   assign reg_waddr_o = reg_waddr_q;
   assign funct3_o    = funct3_q;
   assign alt_o       = alt_q;
   assign is_m_o      = is_m_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_rm_pipe.sv
// Self-checking bench for id_rm_pipe (MAX_PEND = 2).
// Latency: n/a. Backpressure: driven directly from the stimulus.
// Reference model: list of pending M destinations plus an expected output slot.
module tb_id_rm_pipe;

   logic        clk;
   logic        rst;
   logic        inst_valid;
   logic [31:0] inst;
   logic        inst_ready;
   logic [4:0]  ra1, ra2;
   logic        re1, re2;
   logic [31:0] rd1, rd2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op1, op2;
   logic        we;
   logic [4:0]  waddr;
   logic [2:0]  f3_o;
   logic        alt, is_m, ill;
   logic        wb_valid;
   logic [4:0]  wb_addr;

   logic [31:0] rf [32];
   assign rd1 = rf[ra1];
   assign rd2 = rf[ra2];

   id_rm_pipe #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .MAX_PEND(2)) dut (
      .clk(clk), .rst(rst),
      .inst_valid_i(inst_valid), .inst_i(inst), .inst_ready_o(inst_ready),
      .reg1_raddr_o(ra1), .reg2_raddr_o(ra2), .reg1_re_o(re1), .reg2_re_o(re2),
      .reg1_rdata_i(rd1), .reg2_rdata_i(rd2),
      .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .op1_o(op1), .op2_o(op2), .reg_we_o(we), .reg_waddr_o(waddr),
      .funct3_o(f3_o), .alt_o(alt), .is_m_o(is_m), .illegal_o(ill),
      .m_wb_valid_i(wb_valid), .m_wb_addr_i(wb_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit          e_valid;
   logic [31:0] e_op1, e_op2;
   bit          e_we, e_alt, e_ism, e_ill;
   logic [4:0]  e_waddr;
   logic [2:0]  e_f3;
   int          pend[$];
   bit          obs_ready;

   localparam int MAXP = 2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_busy(input int r);
      if (r == 0) return 1'b0;
      foreach (pend[i]) if (pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: check combinational outputs mid-cycle, clock, advance the
   // model, then check the registered outputs.
   task automatic step();
      int rd, rs1, rs2, kind;  // kind: 0 other, 1 alu, 2 mul, 3 illegal
      bit rm, hz, e_rdy, acc;
      logic [31:0] d1, d2;
      #2;
      rd  = int'(inst[11:7]);
      rs1 = int'(inst[19:15]);
      rs2 = int'(inst[24:20]);
      kind = 0;
      if (inst[6:0] == 7'h33) begin
         if (inst[31:25] == 7'h00 || inst[31:25] == 7'h20) kind = 1;
         else if (inst[31:25] == 7'h01) kind = 2;
         else kind = 3;
      end
      rm = inst_valid && (kind == 1 || kind == 2);
      hz = rm && (is_busy(rs1) || is_busy(rs2) || is_busy(rd) ||
                  (kind == 2 && pend.size() == MAXP));
      e_rdy = !rst && (!e_valid || out_ready) && !hz && !flush;
      acc = inst_valid && e_rdy;
      chk("inst_ready", 64'(inst_ready), 64'(e_rdy));
      chk("raddr1", 64'(ra1), rm ? 64'(rs1) : 64'd0);
      chk("raddr2", 64'(ra2), rm ? 64'(rs2) : 64'd0);
      chk("re1", 64'(re1), 64'(rm));
      chk("re2", 64'(re2), 64'(rm));
      obs_ready = inst_ready;
      d1 = rf[rs1];
      d2 = rf[rs2];
      @(posedge clk);
      #1;
      if (rst) begin
         e_valid = 0; e_op1 = 0; e_op2 = 0; e_we = 0; e_waddr = 0;
         e_f3 = 0; e_alt = 0; e_ism = 0; e_ill = 0;
         pend.delete();
      end else begin
         if (flush) e_valid = 0;
         else if (acc) begin
            e_valid = 1; e_op1 = 0; e_op2 = 0; e_we = 0; e_waddr = 0;
            e_f3 = 0; e_alt = 0; e_ism = 0; e_ill = 0;
            if (kind == 1 || kind == 2) begin
               e_op1 = d1; e_op2 = d2; e_we = 1; e_waddr = 5'(rd);
               e_f3 = inst[14:12]; e_alt = inst[30]; e_ism = (kind == 2);
            end else if (kind == 3) e_ill = 1;
         end else if (out_ready) e_valid = 0;
         if (wb_valid) begin
            foreach (pend[i]) if (pend[i] == int'(wb_addr)) begin
               pend.delete(i);
               break;
            end
         end
         if (acc && kind == 2 && rd != 0) pend.push_back(rd);
      end
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      if (e_valid || rst) begin
         chk("op1", 64'(op1), 64'(e_op1));
         chk("op2", 64'(op2), 64'(e_op2));
         chk("reg_we", 64'(we), 64'(e_we));
         chk("reg_waddr", 64'(waddr), 64'(e_waddr));
         chk("funct3", 64'(f3_o), 64'(e_f3));
         chk("alt", 64'(alt), 64'(e_alt));
         chk("is_m", 64'(is_m), 64'(e_ism));
         chk("illegal", 64'(ill), 64'(e_ill));
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] i);
      inst_valid = v;
      inst = i;
   endtask

   initial begin
      logic [6:0] f7, opc;
      int sel;
      for (int r = 0; r < 32; r++) rf[r] = 32'(r * 16 + 3);
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rst = 1; flush = 0; out_ready = 1; wb_valid = 0; wb_addr = 0;
      drive(1'b0, 32'h0);
      e_valid = 0; e_op1 = 0; e_op2 = 0; e_we = 0; e_waddr = 0;
      e_f3 = 0; e_alt = 0; e_ism = 0; e_ill = 0;

      // Reset state
      step();
      step();
      chk("reset_ready_low", 64'(obs_ready), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      rst = 0;

      // add x3,x1,x2
      drive(1'b1, 32'h002081B3);
      step();
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_op1", 64'(op1), 64'd5);
      chk("add_op2", 64'(op2), 64'd7);
      chk("add_waddr", 64'(waddr), 64'd3);
      chk("add_we", 64'(we), 64'd1);

      // mul x5 then dependent add x6,x5,x1
      drive(1'b1, 32'h022082B3);
      step();
      chk("mul_is_m", 64'(is_m), 64'd1);
      drive(1'b1, 32'h00128333);
      step();
      chk("raw_stall1", 64'(obs_ready), 64'd0);
      step();
      chk("raw_stall2", 64'(obs_ready), 64'd0);
      wb_valid = 1; wb_addr = 5'd5;
      step();
      chk("raw_stall_wb_cycle", 64'(obs_ready), 64'd0);
      wb_valid = 0;
      step();
      chk("raw_release", 64'(obs_ready), 64'd1);
      chk("raw_waddr", 64'(waddr), 64'd6);

      // Pending limit of 2: third M-op stalls until any writeback
      drive(1'b1, 32'h022082B3); step();
      drive(1'b1, 32'h02208333); step();
      drive(1'b1, 32'h022083B3); step();
      chk("full_stall1", 64'(obs_ready), 64'd0);
      step();
      chk("full_stall2", 64'(obs_ready), 64'd0);
      wb_valid = 1; wb_addr = 5'd6;
      step();
      chk("full_stall_wb_cycle", 64'(obs_ready), 64'd0);
      wb_valid = 0;
      step();
      chk("full_release", 64'(obs_ready), 64'd1);
      chk("full_waddr", 64'(waddr), 64'd7);
      drive(1'b0, 32'h0);
      wb_valid = 1; wb_addr = 5'd5; step();
      wb_valid = 1; wb_addr = 5'd7; step();
      wb_valid = 1; wb_addr = 5'd9; step();   // non-busy address: ignored
      wb_valid = 0;

      // Output backpressure then flush
      drive(1'b1, 32'h002081B3);
      out_ready = 0;
      step();
      drive(1'b1, 32'h00208233);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_ready", 64'(obs_ready), 64'd0);
         chk("hold_op1", 64'(op1), 64'd5);
         chk("hold_waddr", 64'(waddr), 64'd3);
      end
      flush = 1;
      step();
      chk("flush_ready", 64'(obs_ready), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      flush = 0;
      out_ready = 1;

      // Illegal funct7, bubble opcode
      drive(1'b1, 32'h422081B3);
      step();
      chk("illegal_flag", 64'(ill), 64'd1);
      chk("illegal_we", 64'(we), 64'd0);
      drive(1'b1, 32'h00100093);
      step();
      chk("bubble_valid", 64'(out_valid), 64'd1);
      chk("bubble_we", 64'(we), 64'd0);

      // Reset in the middle of a stall
      drive(1'b1, 32'h022082B3); step();
      drive(1'b1, 32'h00128333); step();
      chk("pre_rst_stall", 64'(obs_ready), 64'd0);
      rst = 1;
      step();
      chk("rst_ready_low", 64'(obs_ready), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_op1", 64'(op1), 64'd0);
      chk("rst_we", 64'(we), 64'd0);
      rst = 0;
      step();
      chk("post_rst_accept", 64'(obs_ready), 64'd1);
      chk("post_rst_waddr", 64'(waddr), 64'd6);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         for (int r = 0; r < 32; r++) rf[r] = $urandom;
         sel = $urandom_range(0, 9);
         f7 = (sel < 4) ? 7'h00 : (sel < 6) ? 7'h20 : (sel < 9) ? 7'h01 : 7'($urandom);
         opc = ($urandom_range(0, 9) < 8) ? 7'h33 : 7'($urandom);
         inst = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 3'($urandom), 5'($urandom_range(0, 7)), opc};
         inst_valid = ($urandom_range(0, 9) < 8);
         flush = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_valid = 1;
            wb_addr = 5'(pend[$urandom_range(0, pend.size() - 1)]);
         end else begin
            wb_valid = ($urandom_range(0, 9) == 0);
            wb_addr = 5'($urandom_range(0, 7));
         end
         rst = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
